// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 encodings and the D->E pipeline register layout for decode_stage.
package decode_stage_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 15;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_e;

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RRSP   = 4'h4;
  localparam logic [3:0] ALUADD = 4'h0;

  // Condition codes carried in ifun for JXX / CMOVXX.
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [2:0]      stat;
    logic [XLEN-1:0] val_a;
    logic [XLEN-1:0] val_b;
    logic [XLEN-1:0] val_c;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
    logic [3:0]      src_a;
    logic [3:0]      src_b;
  } e_reg_t;

  function automatic e_reg_t bubble_e();
    e_reg_t b;
    b.icode = INOP;
    b.ifun  = 4'h0;
    b.stat  = SAOK;
    b.val_a = '0;
    b.val_b = '0;
    b.val_c = '0;
    b.dst_e = RNONE;
    b.dst_m = RNONE;
    b.src_a = RNONE;
    b.src_b = RNONE;
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 15x64 register file: two write ports (M port wins on collision), two async reads.
// REGFILE_DBG_EN adds a combinational debug read port.
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      wr_e_addr_i,
  input  logic [XLEN-1:0] wr_e_data_i,
  input  logic [3:0]      wr_m_addr_i,
  input  logic [XLEN-1:0] wr_m_data_i,
  input  logic [3:0]      rd_a_addr_i,
  input  logic [3:0]      rd_b_addr_i,
`ifdef REGFILE_DBG_EN
  input  logic [3:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o,
`endif
  output logic [XLEN-1:0] rd_a_data_o,
  output logic [XLEN-1:0] rd_b_data_o
);

  logic [XLEN-1:0] regs_w [NREG];

  // RNONE (15) never matches any register index, so it is ignored for free.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [XLEN-1:0] reg_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        reg_q <= '0;
      end else if (wr_m_addr_i == 4'(gi)) begin
        reg_q <= wr_m_data_i;
      end else if (wr_e_addr_i == 4'(gi)) begin
        reg_q <= wr_e_data_i;
      end
    end

    assign regs_w[gi] = reg_q;
  end

  always_comb begin
    rd_a_data_o = '0;
    rd_b_data_o = '0;
    if (rd_a_addr_i != RNONE) rd_a_data_o = regs_w[rd_a_addr_i];
    if (rd_b_addr_i != RNONE) rd_b_data_o = regs_w[rd_b_addr_i];
  end

`ifdef REGFILE_DBG_EN
  always_comb begin
    dbg_data_o = '0;
    if (dbg_addr_i != RNONE) dbg_data_o = regs_w[dbg_addr_i];
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: register IDs, forwarded operands and the D->E register.
// REGFILE_DBG_EN exposes a debug read port on the register file.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      D_icode_i,
  input  logic [3:0]      D_ifun_i,
  input  logic [2:0]      D_stat_i,
  input  logic [3:0]      D_rA_i,
  input  logic [3:0]      D_rB_i,
  input  logic [XLEN-1:0] D_valC_i,
  input  logic [XLEN-1:0] D_valP_i,
  input  logic [3:0]      e_dstE_i,
  input  logic [XLEN-1:0] e_valE_i,
  input  logic [3:0]      M_dstE_i,
  input  logic [3:0]      M_dstM_i,
  input  logic [XLEN-1:0] M_valE_i,
  input  logic [XLEN-1:0] m_valM_i,
  input  logic [3:0]      W_dstE_i,
  input  logic [3:0]      W_dstM_i,
  input  logic [XLEN-1:0] W_valE_i,
  input  logic [XLEN-1:0] W_valM_i,
  input  logic            E_stall_i,
  input  logic            E_bubble_i,
`ifdef REGFILE_DBG_EN
  input  logic [3:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o,
`endif
  output logic [3:0]      E_icode_o,
  output logic [3:0]      E_ifun_o,
  output logic [2:0]      E_stat_o,
  output logic [XLEN-1:0] E_valA_o,
  output logic [XLEN-1:0] E_valB_o,
  output logic [XLEN-1:0] E_valC_o,
  output logic [3:0]      E_dstE_o,
  output logic [3:0]      E_dstM_o,
  output logic [3:0]      E_srcA_o,
  output logic [3:0]      E_srcB_o
);

  logic [3:0]      src_a, src_b, dst_e, dst_m;
  logic [XLEN-1:0] rf_a, rf_b, val_a, val_b;
  e_reg_t          e_q, e_d;

  decode_stage_regfile u_regfile (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_e_addr_i (W_dstE_i),
    .wr_e_data_i (W_valE_i),
    .wr_m_addr_i (W_dstM_i),
    .wr_m_data_i (W_valM_i),
    .rd_a_addr_i (src_a),
    .rd_b_addr_i (src_b),
`ifdef REGFILE_DBG_EN
    .dbg_addr_i  (dbg_addr_i),
    .dbg_data_o  (dbg_data_o),
`endif
    .rd_a_data_o (rf_a),
    .rd_b_data_o (rf_b)
  );

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode_i)
      IRRMOVQ: begin src_a = D_rA_i; dst_e = D_rB_i; end
      IIRMOVQ: dst_e = D_rB_i;
      IRMMOVQ: begin src_a = D_rA_i; src_b = D_rB_i; end
      IMRMOVQ: begin src_b = D_rB_i; dst_m = D_rA_i; end
      IOPQ:    begin src_a = D_rA_i; src_b = D_rB_i; dst_e = D_rB_i; end
      IPUSHQ:  begin src_a = D_rA_i; src_b = RRSP; dst_e = RRSP; end
      IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = D_rA_i; end
      ICALL:   begin src_b = RRSP; dst_e = RRSP; end
      IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      default: ;
    endcase
  end

  // Youngest producer wins; a W-stage write lands only at the edge, so W is forwarded too.
  function automatic logic [XLEN-1:0] fwd(input logic [3:0] src, input logic [XLEN-1:0] rf);
    if (src == RNONE)         return '0;
    else if (src == e_dstE_i) return e_valE_i;
    else if (src == M_dstM_i) return m_valM_i;
    else if (src == M_dstE_i) return M_valE_i;
    else if (src == W_dstM_i) return W_valM_i;
    else if (src == W_dstE_i) return W_valE_i;
    else                      return rf;
  endfunction

  always_comb begin
    if (D_icode_i == ICALL || D_icode_i == IJXX) begin
      val_a = D_valP_i;
    end else begin
      val_a = fwd(src_a, rf_a);
    end
    val_b = fwd(src_b, rf_b);
  end

  always_comb begin
    e_d = e_q;
    if (E_bubble_i) begin
      e_d = bubble_e();
    end else if (!E_stall_i) begin
      e_d.icode = D_icode_i;
      e_d.ifun  = D_ifun_i;
      e_d.stat  = D_stat_i;
      e_d.val_a = val_a;
      e_d.val_b = val_b;
      e_d.val_c = D_valC_i;
      e_d.dst_e = dst_e;
      e_d.dst_m = dst_m;
      e_d.src_a = src_a;
      e_d.src_b = src_b;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q <= bubble_e();
    end else begin
      e_q <= e_d;
    end
  end

  assign E_icode_o = e_q.icode;
  assign E_ifun_o  = e_q.ifun;
  assign E_stat_o  = e_q.stat;
  assign E_valA_o  = e_q.val_a;
  assign E_valB_o  = e_q.val_b;
  assign E_valC_o  = e_q.val_c;
  assign E_dstE_o  = e_q.dst_e;
  assign E_dstM_o  = e_q.dst_m;
  assign E_srcA_o  = e_q.src_a;
  assign E_srcB_o  = e_q.src_b;

endmodule
